// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
//   Shared definitions for the RV32I multi-cycle controller: state encodings,
//   opcode constants, ALUOp / MemtoReg codes and the EXEC-phase ALU select
//   decode. Imported by multicycle_ctrl_if, mem_wait_timer and multicycle_ctrl.
package multicycle_ctrl_pkg;

  localparam int OPCODE_W = 7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BR    = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef struct packed {
    logic       src_a;
    logic       src_b;
    logic [1:0] alu_op;
  } alu_sel_t;

  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BR,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opcode_legal = 1'b1;
      default:                               opcode_legal = 1'b0;
    endcase
  endfunction

  // ALU operand/operation selects used in EXEC and held through MEM.
  function automatic alu_sel_t exec_sel(input logic [OPCODE_W-1:0] opc);
    case (opc)
      OPC_R:                       exec_sel = '{1'b0, 1'b0, ALUOP_FUNCT};
      OPC_I:                       exec_sel = '{1'b0, 1'b1, ALUOP_FUNCT};
      OPC_LOAD, OPC_STORE,
      OPC_JALR:                    exec_sel = '{1'b0, 1'b1, ALUOP_ADD};
      OPC_BR:                      exec_sel = '{1'b0, 1'b0, ALUOP_BR};
      OPC_JAL, OPC_AUIPC:          exec_sel = '{1'b1, 1'b1, ALUOP_ADD};
      OPC_LUI:                     exec_sel = '{1'b0, 1'b1, ALUOP_PASSB};
      default:                     exec_sel = '{1'b0, 1'b0, ALUOP_ADD};
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Controller <-> datapath/memory bundle.
//   master (controller): in  opcode, br_cond, mem_ready
//                        out PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
//                            RegWrite, ALUSrcA, ALUSrcB, MemtoReg, ALUOp,
//                            bus_err, state
//   slave (datapath side): the mirror image.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                br_cond;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCSrc;
  logic                IRWrite;
  logic                MemRead;
  logic                MemWrite;
  logic                RegWrite;
  logic                ALUSrcA;
  logic                ALUSrcB;
  logic [1:0]          MemtoReg;
  logic [1:0]          ALUOp;
  logic                bus_err;
  logic [2:0]          state;

  modport master (
    input  opcode, br_cond, mem_ready,
    output PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, MemtoReg, ALUOp, bus_err, state
  );

  modport slave (
    output opcode, br_cond, mem_ready,
    input  PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, MemtoReg, ALUOp, bus_err, state
  );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer
//   Counts consecutive not-ready cycles while the controller waits on memory
//   (FETCH or MEM) and flags a timeout on the WAIT_MAX-th such cycle.
//   Ports: clk, rst (sync, active-high), state (current controller state),
//          state_change (controller moves to another state this cycle),
//          mem_ready, timeout (out, combinational).
module mem_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  input  logic   state_change,
  input  logic   mem_ready,
  output logic   timeout
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] wait_cnt_reg;
  logic [CW-1:0] wait_cnt_next;
  logic          waiting;

  assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  // A ready in the last allowed cycle suppresses the timeout because waiting is 0.
  assign timeout = waiting && (wait_cnt_reg == CW'(WAIT_MAX - 1));

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_change || !waiting) begin
      wait_cnt_next = '0;
    end else begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath.
//   Ports: clk, rst (sync, active-high), bus (multicycle_ctrl_if.master:
//          opcode/br_cond/mem_ready in; PC/IR/reg/mem strobes, mux selects,
//          ALUOp, sticky bus_err and debug state out).
//   Optional: define MULTICYCLE_CTRL_PERF_EN to add cycle_cnt / instret_cnt
//          output ports (CNT_W bits, wrapping).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt
`endif
);

  state_t     state_reg;
  state_t     state_next;
  logic       bus_err_reg;
  logic       timeout;
  logic       state_change;
  alu_sel_t   sel;

  logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
  logic       alu_src_a, alu_src_b;
  logic [1:0] alu_op, mem_to_reg;

  logic is_load, is_store, is_jump;
  assign is_load  = (bus.opcode == OPC_LOAD);
  assign is_store = (bus.opcode == OPC_STORE);
  assign is_jump  = (bus.opcode == OPC_JAL) || (bus.opcode == OPC_JALR);

  assign state_change = (state_next != state_reg);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .state        (state_reg),
    .state_change (state_change),
    .mem_ready    (bus.mem_ready),
    .timeout      (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_err_reg <= bus_err_reg | (state_next == ST_ERR);
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALUOP_ADD;
    mem_to_reg = MTR_ALU;
    sel        = exec_sel(bus.opcode);

    case (state_reg)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_ERR;
        end
      end
      ST_DECODE: begin
        state_next = opcode_legal(bus.opcode) ? ST_EXEC : ST_ERR;
      end
      ST_EXEC: begin
        {alu_src_a, alu_src_b, alu_op} = sel;
        if (bus.opcode == OPC_BR) begin
          // Branches retire here: the only PC update for this instruction.
          pc_write   = 1'b1;
          pc_src     = bus.br_cond;
          state_next = ST_FETCH;
        end else if (is_load || is_store) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        // Address comes from ALUResult, so keep the EXEC selects stable.
        {alu_src_a, alu_src_b, alu_op} = sel;
        mem_read  = is_load;
        mem_write = !is_load;
        if (bus.mem_ready) begin
          if (is_load) begin
            state_next = ST_WB;
          end else begin
            pc_write   = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (timeout) begin
          state_next = ST_ERR;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = is_jump;
        mem_to_reg = is_load ? MTR_MEM : (is_jump ? MTR_PC4 : MTR_ALU);
        state_next = ST_FETCH;
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_ERR;
      end
    endcase

    // Reset overrides every strobe, even mid-instruction.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.PCWrite  = pc_write;
  assign bus.PCSrc    = pc_src;
  assign bus.IRWrite  = ir_write;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.bus_err  = bus_err_reg;
  assign bus.state    = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [CNT_W-1:0] instret_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (pc_write) begin
        instret_cnt_reg <= instret_cnt_reg + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. Each scenario queues per-cycle
//   expectations (input drive + expected output pattern), then pops them one
//   per clock and compares the sampled outputs. Pattern string columns:
//   state(3)_PCWrite PCSrc_IRWrite MemRead MemWrite RegWrite_ALUSrcA ALUSrcB
//   _ALUOp_MemtoReg_bus_err ; '-' marks a bit that is not checked.
//   Honours MULTICYCLE_CTRL_PERF_EN for the perf counter ports.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic clk;
  logic rst;
  logic [15:0] obs;
  int checks;
  int failures;

  multicycle_ctrl_if ctrl ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
`endif

  multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ctrl.master)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r;
    logic        rdy;
    logic        brc;
    logic [15:0] val;
    logic [15:0] mask;
  } step_t;

  step_t sb[$];

  localparam string F_RDY  = "000_0-_1100_--_--_--_0";
  localparam string F_WT   = "000_0-_0100_--_--_--_0";
  localparam string DEC    = "001_0-_0000_--_--_--_0";
  localparam string EX_R   = "010_0-_0000_00_10_--_0";
  localparam string WB_ALU = "100_10_0001_--_--_00_0";
  localparam string ERR_P  = "111_0-_0000_--_--_--_1";

  function automatic void push(string nm, logic r, logic rdy, logic brc, string pat);
    step_t s;
    byte   c;
    s.name = nm; s.r = r; s.rdy = rdy; s.brc = brc;
    s.val = '0; s.mask = '0;
    for (int i = 0; i < pat.len(); i++) begin
      c = pat[i];
      if (c != "_") begin
        s.val  = {s.val[14:0], (c == "1")};
        s.mask = {s.mask[14:0], (c != "-")};
      end
    end
    sb.push_back(s);
  endfunction

  task automatic cyc(input logic r, input logic rdy, input logic brc);
    @(negedge clk);
    rst = r;
    ctrl.mem_ready = rdy;
    ctrl.br_cond = brc;
    #1;
    obs = {ctrl.state, ctrl.PCWrite, ctrl.PCSrc, ctrl.IRWrite, ctrl.MemRead,
           ctrl.MemWrite, ctrl.RegWrite, ctrl.ALUSrcA, ctrl.ALUSrcB,
           ctrl.ALUOp, ctrl.MemtoReg, ctrl.bus_err};
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step_t s;
    cyc(1'b1, 1'b1, 1'b0);
    push("rst_fetch_gated", 1'b1, 1'b1, 1'b0, "000_0-_0000_--_--_--_0");
    push("post_rst_fetch", 1'b0, 1'b0, 1'b0, F_WT);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    do_reset();
    checks++;
    if (instret_cnt !== '0 || cycle_cnt !== '0) begin
      failures++;
      $display("FAIL perf_reset: got cycle=%0d instret=%0d required 0 0", cycle_cnt, instret_cnt);
    end
`endif
  endtask

  task automatic test_add();
    step_t s;
    ctrl.opcode = OPC_R;
    push("add_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("add_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("add_exec", 1'b0, 1'b1, 1'b0, EX_R);
    push("add_wb", 1'b0, 1'b1, 1'b0, WB_ALU);
    push("add_next_fetch", 1'b0, 1'b0, 1'b0, F_WT);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_load_wait();
    step_t s;
    ctrl.opcode = OPC_LOAD;
    push("lw_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("lw_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("lw_exec", 1'b0, 1'b1, 1'b0, "010_0-_0000_01_00_--_0");
    for (int i = 0; i < 3; i++) push("lw_mem_wait", 1'b0, 1'b0, 1'b0, "011_0-_0100_01_00_--_0");
    push("lw_mem_ready", 1'b0, 1'b1, 1'b0, "011_0-_0100_01_00_--_0");
    push("lw_wb", 1'b0, 1'b1, 1'b0, "100_10_0001_--_--_01_0");
    push("lw_next_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("lw2_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("lw2_exec", 1'b0, 1'b1, 1'b0, "010_0-_0000_01_00_--_0");
    push("lw2_mem_ready", 1'b0, 1'b1, 1'b0, "011_0-_0100_01_00_--_0");
    push("lw2_wb", 1'b0, 1'b1, 1'b0, "100_10_0001_--_--_01_0");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_branch();
    step_t s;
    ctrl.opcode = OPC_BR;
    push("beq_t_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("beq_t_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("beq_t_exec", 1'b0, 1'b1, 1'b1, "010_11_0000_00_01_--_0");
    push("beq_n_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("beq_n_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("beq_n_exec", 1'b0, 1'b1, 1'b0, "010_10_0000_00_01_--_0");
    push("beq_next_fetch", 1'b0, 1'b0, 1'b0, F_WT);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_jal();
    step_t s;
    ctrl.opcode = OPC_JAL;
    push("jal_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("jal_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("jal_exec", 1'b0, 1'b1, 1'b0, "010_0-_0000_11_00_--_0");
    push("jal_wb", 1'b0, 1'b1, 1'b0, "100_11_0001_--_--_10_0");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_exec_selects();
    step_t s;
    logic [6:0] opcs [4];
    string ex_pat [4];
    string wb_pat [4];
    opcs[0] = OPC_I;     ex_pat[0] = "010_0-_0000_01_10_--_0"; wb_pat[0] = WB_ALU;
    opcs[1] = OPC_LUI;   ex_pat[1] = "010_0-_0000_-1_11_--_0"; wb_pat[1] = WB_ALU;
    opcs[2] = OPC_AUIPC; ex_pat[2] = "010_0-_0000_11_00_--_0"; wb_pat[2] = WB_ALU;
    opcs[3] = OPC_JALR;  ex_pat[3] = "010_0-_0000_01_00_--_0"; wb_pat[3] = "100_11_0001_--_--_10_0";
    for (int k = 0; k < 4; k++) begin
      ctrl.opcode = opcs[k];
      push($sformatf("sel%0d_fetch", k), 1'b0, 1'b1, 1'b0, F_RDY);
      push($sformatf("sel%0d_decode", k), 1'b0, 1'b1, 1'b0, DEC);
      push($sformatf("sel%0d_exec", k), 1'b0, 1'b1, 1'b0, ex_pat[k]);
      push($sformatf("sel%0d_wb", k), 1'b0, 1'b1, 1'b0, wb_pat[k]);
      while (sb.size() > 0) begin
        s = sb.pop_front();
        cyc(s.r, s.rdy, s.brc);
        checks++;
        $display("step %s obs=%b", s.name, obs);
        if ((obs & s.mask) !== (s.val & s.mask)) begin
          failures++;
          $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
        end
      end
    end
  endtask

  task automatic test_store_reset();
    step_t s;
    ctrl.opcode = OPC_STORE;
    push("sw_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("sw_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("sw_exec", 1'b0, 1'b1, 1'b0, "010_0-_0000_01_00_--_0");
    push("sw_mem_ready", 1'b0, 1'b1, 1'b0, "011_10_0010_01_00_--_0");
    push("sw2_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("sw2_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("sw2_exec", 1'b0, 1'b1, 1'b0, "010_0-_0000_01_00_--_0");
    push("sw2_mem_wait", 1'b0, 1'b0, 1'b0, "011_0-_0010_01_00_--_0");
    push("sw2_mem_rst", 1'b1, 1'b1, 1'b0, "011_0-_0000_--_--_--_0");
    push("sw2_after_rst", 1'b0, 1'b0, 1'b0, F_WT);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s;
    do_reset();
    ctrl.opcode = OPC_R;
    for (int i = 0; i < 15; i++) push($sformatf("to_wait%0d", i), 1'b0, 1'b0, 1'b0, F_WT);
    for (int i = 0; i < 3; i++) push($sformatf("to_err%0d", i), 1'b0, 1'b1, 1'b0, ERR_P);
    push("to_rst_in_err", 1'b1, 1'b1, 1'b0, ERR_P);
    push("to_rst_clear", 1'b1, 1'b1, 1'b0, "000_0-_0000_--_--_--_0");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_timeout_recover();
    step_t s;
    do_reset();
    ctrl.opcode = OPC_R;
    for (int i = 0; i < 14; i++) push($sformatf("tr_wait%0d", i), 1'b0, 1'b0, 1'b0, F_WT);
    push("tr_ready_last", 1'b0, 1'b1, 1'b0, F_RDY);
    push("tr_decode", 1'b0, 1'b1, 1'b0, DEC);
    push("tr_exec", 1'b0, 1'b1, 1'b0, EX_R);
    push("tr_wb", 1'b0, 1'b1, 1'b0, WB_ALU);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s;
    do_reset();
    ctrl.opcode = 7'b0000000;
    push("ill_fetch", 1'b0, 1'b1, 1'b0, F_RDY);
    push("ill_decode", 1'b0, 1'b1, 1'b0, DEC);
    for (int i = 0; i < 3; i++) push($sformatf("ill_err%0d", i), 1'b0, 1'b1, 1'b1, ERR_P);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  task automatic test_perf();
    step_t s;
    do_reset();
    ctrl.opcode = OPC_R;
    for (int i = 0; i < 10; i++) begin
      push($sformatf("perf%0d_fetch", i), 1'b0, 1'b1, 1'b0, F_RDY);
      push($sformatf("perf%0d_decode", i), 1'b0, 1'b1, 1'b0, DEC);
      push($sformatf("perf%0d_exec", i), 1'b0, 1'b1, 1'b0, EX_R);
      push($sformatf("perf%0d_wb", i), 1'b0, 1'b1, 1'b0, WB_ALU);
    end
    while (sb.size() > 0) begin
      s = sb.pop_front();
      cyc(s.r, s.rdy, s.brc);
      checks++;
      $display("step %s obs=%b", s.name, obs);
      if ((obs & s.mask) !== (s.val & s.mask)) begin
        failures++;
        $display("FAIL %s: got %b required %b care %b", s.name, obs, s.val, s.mask);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (instret_cnt !== CNT_W'(10)) begin
      failures++;
      $display("FAIL perf_instret: got %0d required 10", instret_cnt);
    end
    checks++;
    if (cycle_cnt !== CNT_W'(40)) begin
      failures++;
      $display("FAIL perf_cycles: got %0d required 40", cycle_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ctrl.opcode = OPC_R;
    ctrl.br_cond = 1'b0;
    ctrl.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jal();
    test_exec_selects();
    test_store_reset();
    test_timeout();
    test_timeout_recover();
    test_illegal();
`ifdef MULTICYCLE_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
